// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported RAM between instruction fetch and the MEM stage; data wins.
// Define ARB_WDOG_EN to abort accesses whose ack never arrives (sticky err_o).
module mem_port_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WDOG_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_data_o,
    output logic                if_done_o,
    input  logic                flush_i,
    output logic                stallreq_from_if,
    input  logic                dm_req_i,
    input  logic                dm_we_i,
    input  logic [DATA_W/8-1:0] dm_sel_i,
    input  logic [ADDR_W-1:0]   dm_addr_i,
    input  logic [DATA_W-1:0]   dm_wdata_i,
    output logic [DATA_W-1:0]   dm_rdata_o,
    output logic                dm_done_o,
    output logic                stallreq_from_mem,
    output logic                ram_req_o,
    output logic                ram_we_o,
    output logic [DATA_W/8-1:0] ram_sel_o,
    output logic [ADDR_W-1:0]   ram_addr_o,
    output logic [DATA_W-1:0]   ram_wdata_o,
    input  logic [DATA_W-1:0]   ram_rdata_i,
    input  logic                ram_ack_i,
    output logic                err_o
);

    typedef enum logic [1:0] {IDLE, DM_BUSY, IF_BUSY} state_t;

    state_t                state, state_n;
    logic                  ram_req_n, ram_we_n;
    logic [DATA_W/8-1:0]   ram_sel_n;
    logic [ADDR_W-1:0]     ram_addr_n;
    logic [DATA_W-1:0]     ram_wdata_n, if_data_n, dm_rdata_n;
    logic                  if_done_q, if_done_n, dm_done_n;
    logic                  kill, kill_n;
    logic                  abort;

    assign if_done_o         = if_done_q & ~flush_i;
    assign stallreq_from_if  = if_req_i & ~if_done_o;
    assign stallreq_from_mem = dm_req_i & ~dm_done_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ram_req_o   <= 1'b0;
            ram_we_o    <= 1'b0;
            ram_sel_o   <= '0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
            if_data_o   <= '0;
            dm_rdata_o  <= '0;
            if_done_q   <= 1'b0;
            dm_done_o   <= 1'b0;
            kill        <= 1'b0;
        end else begin
            state       <= state_n;
            ram_req_o   <= ram_req_n;
            ram_we_o    <= ram_we_n;
            ram_sel_o   <= ram_sel_n;
            ram_addr_o  <= ram_addr_n;
            ram_wdata_o <= ram_wdata_n;
            if_data_o   <= if_data_n;
            dm_rdata_o  <= dm_rdata_n;
            if_done_q   <= if_done_n;
            dm_done_o   <= dm_done_n;
            kill        <= kill_n;
        end
    end

    always_comb begin
        state_n     = state;
        ram_req_n   = ram_req_o;
        ram_we_n    = ram_we_o;
        ram_sel_n   = ram_sel_o;
        ram_addr_n  = ram_addr_o;
        ram_wdata_n = ram_wdata_o;
        if_data_n   = if_data_o;
        dm_rdata_n  = dm_rdata_o;
        if_done_n   = 1'b0;
        dm_done_n   = 1'b0;
        kill_n      = kill;
        unique case (state)
            IDLE: begin
                kill_n = 1'b0;
                // A requester in its done cycle still holds req; masking it avoids a replay.
                if (dm_req_i && !dm_done_o) begin
                    ram_req_n   = 1'b1;
                    ram_we_n    = dm_we_i;
                    ram_sel_n   = dm_sel_i;
                    ram_addr_n  = dm_addr_i;
                    ram_wdata_n = dm_wdata_i;
                    state_n     = DM_BUSY;
                end else if (if_req_i && !if_done_o && !flush_i) begin
                    ram_req_n  = 1'b1;
                    ram_we_n   = 1'b0;
                    ram_sel_n  = '1;
                    ram_addr_n = if_addr_i;
                    state_n    = IF_BUSY;
                end
            end
            DM_BUSY: begin
                if (ram_ack_i) begin
                    ram_req_n = 1'b0;
                    dm_done_n = 1'b1;
                    state_n   = IDLE;
                    if (!ram_we_o) dm_rdata_n = ram_rdata_i;
                end else if (abort) begin
                    ram_req_n  = 1'b0;
                    dm_done_n  = 1'b1;
                    dm_rdata_n = '0;
                    state_n    = IDLE;
                end
            end
            IF_BUSY: begin
                if (flush_i) kill_n = 1'b1;
                if (ram_ack_i || abort) begin
                    ram_req_n = 1'b0;
                    kill_n    = 1'b0;
                    state_n   = IDLE;
                    // A flush in the completing cycle kills the fetch just like an earlier one.
                    if (!kill && !flush_i) begin
                        if_done_n = 1'b1;
                        if_data_n = ram_ack_i ? ram_rdata_i : '0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef ARB_WDOG_EN
    localparam int unsigned CNT_W = $clog2(WDOG_CYCLES + 1);

    logic [CNT_W-1:0] wdog_cnt;
    logic             err_q;

    // Abort on the edge that would bring the count to WDOG_CYCLES.
    assign abort = (state != IDLE) && !ram_ack_i && (wdog_cnt == CNT_W'(WDOG_CYCLES - 1));
    assign err_o = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == IDLE)  wdog_cnt <= '0;
            else if (!ram_ack_i) wdog_cnt <= wdog_cnt + CNT_W'(1);
            if (abort) err_q <= 1'b1;
        end
    end
`else
    logic unused_wdog;
    assign unused_wdog = ^WDOG_CYCLES;
    assign abort       = 1'b0;
    assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed corner cases plus randomized traffic against a transaction-timing model.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              if_req_i = 1'b0, flush_i = 1'b0;
    logic [ADDR_W-1:0] if_addr_i = '0;
    logic [DATA_W-1:0] if_data_o;
    logic              if_done_o, stallreq_from_if;
    logic              dm_req_i = 1'b0, dm_we_i = 1'b0;
    logic [3:0]        dm_sel_i = '0;
    logic [ADDR_W-1:0] dm_addr_i = '0;
    logic [DATA_W-1:0] dm_wdata_i = '0;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              dm_done_o, stallreq_from_mem;
    logic              ram_req_o, ram_we_o;
    logic [3:0]        ram_sel_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_wdata_o;
    logic [DATA_W-1:0] ram_rdata_i = '0;
    logic              ram_ack_i = 1'b0;
    logic              err_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: last value each requester should be holding.
    logic [DATA_W-1:0] exp_if = '0;
    logic [DATA_W-1:0] exp_dm = '0;

    int unsigned ram_lat = 0;
    int unsigned ram_wait = 0;
    bit          spurious_ack = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WDOG_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_done_o(if_done_o),
        .flush_i(flush_i), .stallreq_from_if(stallreq_from_if),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_sel_i(dm_sel_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .dm_done_o(dm_done_o),
        .stallreq_from_mem(stallreq_from_mem),
        .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .ram_ack_i(ram_ack_i), .err_o(err_o)
    );

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // RAM model: acks after ram_lat waiting cycles; optional junk acks while idle.
    always @(negedge clk) begin
        ram_ack_i = 1'b0;
        if (ram_req_o) begin
            if (ram_wait >= ram_lat) begin
                ram_ack_i   = 1'b1;
                ram_rdata_i = ram_word(ram_addr_o);
                ram_wait    = 0;
            end else begin
                ram_wait++;
            end
        end else begin
            ram_wait = 0;
            if (spurious_ack && ($urandom_range(0, 1) == 1)) ram_ack_i = 1'b1;
        end
        if (!ram_ack_i || !ram_req_o) ram_rdata_i = $urandom;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        if_req_i = 1'b1; if_addr_i = 32'h14;
        dm_req_i = 1'b1; dm_addr_i = 32'h100;
        repeat (3) tick();
        n_tests++;
        if ({ram_req_o, ram_we_o, ram_sel_o, ram_wdata_o, if_data_o, if_done_o,
             dm_rdata_o, dm_done_o, err_o} !== '0) begin
            n_fail++; $display("FAIL reset_outputs got req=%b data=%h/%h exp all 0", ram_req_o, if_data_o, dm_rdata_o);
        end
        n_tests++;
        if (ram_addr_o !== '0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", ram_addr_o); end
        n_tests++;
        if (stallreq_from_if !== 1'b1) begin n_fail++; $display("FAIL reset_stall_if got %b exp 1", stallreq_from_if); end
        n_tests++;
        if (stallreq_from_mem !== 1'b1) begin n_fail++; $display("FAIL reset_stall_mem got %b exp 1", stallreq_from_mem); end
        if_req_i = 1'b0; dm_req_i = 1'b0;
        rst = 1'b0;
        tick();
        n_tests++;
        if (ram_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_release_req got %b exp 0", ram_req_o); end
    endtask

    task automatic test_single_fetch();
        ram_lat = 0; spurious_ack = 1'b0;
        if_req_i = 1'b1; if_addr_i = 32'h0000_0010;
        #1;
        n_tests++;
        if (stallreq_from_if !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_n got %b exp 1", stallreq_from_if); end
        tick();
        n_tests++;
        if (ram_req_o !== 1'b1 || ram_addr_o !== 32'h10 || ram_we_o !== 1'b0 || ram_sel_o !== 4'hF) begin
            n_fail++; $display("FAIL fetch_cmd got req=%b addr=%h we=%b sel=%h exp 1/10/0/f", ram_req_o, ram_addr_o, ram_we_o, ram_sel_o);
        end
        n_tests++;
        if (stallreq_from_if !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_n1 got %b exp 1", stallreq_from_if); end
        tick();
        exp_if = ram_word(32'h10);
        n_tests++;
        if (if_done_o !== 1'b1 || if_data_o !== exp_if) begin
            n_fail++; $display("FAIL fetch_done got done=%b data=%h exp 1/%h", if_done_o, if_data_o, exp_if);
        end
        n_tests++;
        if (stallreq_from_if !== 1'b0 || ram_req_o !== 1'b0) begin
            n_fail++; $display("FAIL fetch_release got stall=%b req=%b exp 0/0", stallreq_from_if, ram_req_o);
        end
        if_req_i = 1'b0;
        tick();
        n_tests++;
        if (if_done_o !== 1'b0 || ram_req_o !== 1'b0 || if_data_o !== exp_if) begin
            n_fail++; $display("FAIL fetch_after got done=%b req=%b data=%h exp 0/0/%h", if_done_o, ram_req_o, if_data_o, exp_if);
        end
    endtask

    task automatic test_flush_done();
        ram_lat = 0; spurious_ack = 1'b0;
        if_req_i = 1'b1; if_addr_i = 32'h20;
        tick();
        tick();
        n_tests++;
        if (if_done_o !== 1'b1) begin n_fail++; $display("FAIL flushd_pre got %b exp 1", if_done_o); end
        flush_i = 1'b1; if_addr_i = 32'h40;
        #1;
        n_tests++;
        if (if_done_o !== 1'b0 || stallreq_from_if !== 1'b1) begin
            n_fail++; $display("FAIL flushd_gate got done=%b stall=%b exp 0/1", if_done_o, stallreq_from_if);
        end
        tick();
        n_tests++;
        if (ram_req_o !== 1'b0) begin n_fail++; $display("FAIL flushd_block got %b exp 0", ram_req_o); end
        flush_i = 1'b0;
        tick();
        n_tests++;
        if (ram_req_o !== 1'b1 || ram_addr_o !== 32'h40) begin
            n_fail++; $display("FAIL flushd_refetch got req=%b addr=%h exp 1/40", ram_req_o, ram_addr_o);
        end
        tick();
        exp_if = ram_word(32'h40);
        n_tests++;
        if (if_done_o !== 1'b1 || if_data_o !== exp_if) begin
            n_fail++; $display("FAIL flushd_done got done=%b data=%h exp 1/%h", if_done_o, if_data_o, exp_if);
        end
        if_req_i = 1'b0;
        tick();
    endtask

`ifdef ARB_WDOG_EN
    task automatic test_watchdog();
        ram_lat = 1000; spurious_ack = 1'b0;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h300; dm_sel_i = 4'hF;
        for (int unsigned t = 1; t <= 7; t++) begin
            tick();
            n_tests++;
            if (ram_req_o !== (t <= 4)) begin n_fail++; $display("FAIL wdog_req t=%0d got %b exp %b", t, ram_req_o, (t <= 4)); end
            n_tests++;
            if (dm_done_o !== (t == 5)) begin n_fail++; $display("FAIL wdog_done t=%0d got %b exp %b", t, dm_done_o, (t == 5)); end
            n_tests++;
            if (err_o !== (t >= 5)) begin n_fail++; $display("FAIL wdog_err t=%0d got %b exp %b", t, err_o, (t >= 5)); end
            if (t == 5) begin
                n_tests++;
                if (dm_rdata_o !== '0) begin n_fail++; $display("FAIL wdog_rdata got %h exp 0", dm_rdata_o); end
            end
            if (t == 6) dm_req_i = 1'b0;
        end
        exp_dm = '0;
    endtask
`endif

    task automatic test_async_reset();
        ram_lat = 6; spurious_ack = 1'b0;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h200; dm_sel_i = 4'hF;
        tick();
        tick();
        n_tests++;
        if (ram_req_o !== 1'b1 || ram_addr_o !== 32'h200) begin
            n_fail++; $display("FAIL areset_busy got req=%b addr=%h exp 1/200", ram_req_o, ram_addr_o);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({ram_req_o, ram_we_o, ram_sel_o, ram_addr_o, ram_wdata_o, if_data_o, if_done_o,
             dm_rdata_o, dm_done_o, err_o} !== '0) begin
            n_fail++; $display("FAIL areset_outputs got req=%b addr=%h data=%h exp all 0", ram_req_o, ram_addr_o, if_data_o);
        end
        dm_req_i = 1'b0;
        exp_if = '0; exp_dm = '0;
        tick();
        rst = 1'b0;
        tick();
        n_tests++;
        if (ram_req_o !== 1'b0 || dm_done_o !== 1'b0) begin
            n_fail++; $display("FAIL areset_idle got req=%b done=%b exp 0/0", ram_req_o, dm_done_o);
        end
        ram_lat = 0;
        if_req_i = 1'b1; if_addr_i = 32'h44;
        tick();
        n_tests++;
        if (ram_req_o !== 1'b1 || ram_addr_o !== 32'h44) begin
            n_fail++; $display("FAIL areset_fetch_cmd got req=%b addr=%h exp 1/44", ram_req_o, ram_addr_o);
        end
        tick();
        exp_if = ram_word(32'h44);
        n_tests++;
        if (if_done_o !== 1'b1 || if_data_o !== exp_if) begin
            n_fail++; $display("FAIL areset_fetch_done got done=%b data=%h exp 1/%h", if_done_o, if_data_o, exp_if);
        end
        if_req_i = 1'b0;
        tick();
    endtask

    // Kinds: 0 fetch, 1 dm read, 2 dm write, 3 dm+fetch together, 4 fetch flushed in flight then redirected.
    // An access arbitrated at edge k with latency L holds ram_req over ticks k..k+L and completes at k+L+1.
    task automatic test_random_traffic(input int unsigned n_iter);
        int unsigned       kind, lat, f, na, t_end;
        int unsigned       ak[2];
        logic [31:0]       aaddr[2], awd[2];
        logic              awe[2];
        logic [3:0]        asel[2];
        bit                adm[2], alive[2];
        spurious_ack = 1'b1;
        for (int unsigned it = 0; it < n_iter; it++) begin
            kind = $urandom_range(0, 4);
            lat  = $urandom_range(0, 3);
            ram_lat = lat;
            na = 1; f = 0;
            ak[0] = 1; alive[0] = 1'b1;
            adm[0] = (kind >= 1 && kind <= 3);
            if (adm[0]) begin
                aaddr[0] = $urandom & 32'hFFFF_FFFC;
                awe[0]   = (kind == 2) ? 1'b1 : ((kind == 3) ? 1'($urandom_range(0, 1)) : 1'b0);
                asel[0]  = 4'($urandom);
                awd[0]   = $urandom;
                dm_req_i = 1'b1; dm_we_i = awe[0]; dm_sel_i = asel[0];
                dm_addr_i = aaddr[0]; dm_wdata_i = awd[0];
            end else begin
                aaddr[0] = $urandom & 32'hFFFF_FFFC;
                awe[0] = 1'b0; asel[0] = 4'hF; awd[0] = '0;
                if_req_i = 1'b1; if_addr_i = aaddr[0];
            end
            if (kind == 3 || kind == 4) begin
                na = 2;
                adm[1] = 1'b0; ak[1] = 3 + lat; alive[1] = 1'b1;
                aaddr[1] = $urandom & 32'hFFFF_FFFC;
                awe[1] = 1'b0; asel[1] = 4'hF; awd[1] = '0;
                if (kind == 3) begin
                    if_req_i = 1'b1; if_addr_i = aaddr[1];
                end else begin
                    alive[0] = 1'b0;
                    f = 1 + $urandom_range(0, lat);
                end
            end
            t_end = ak[na-1] + lat + 2;
            for (int unsigned t = 1; t <= t_end; t++) begin
                bit          e_req, e_ifd, e_dmd;
                int unsigned cur;
                tick();
                e_req = 1'b0; e_ifd = 1'b0; e_dmd = 1'b0; cur = 0;
                for (int unsigned i = 0; i < na; i++) begin
                    if (t >= ak[i] && t <= ak[i] + lat) begin e_req = 1'b1; cur = i; end
                    if (alive[i] && t == ak[i] + lat + 1) begin
                        if (adm[i]) begin
                            e_dmd = 1'b1;
                            if (!awe[i]) exp_dm = ram_word(aaddr[i]);
                        end else begin
                            e_ifd = 1'b1;
                            exp_if = ram_word(aaddr[i]);
                        end
                    end
                end
                n_tests++;
                if (ram_req_o !== e_req) begin n_fail++; $display("FAIL rnd_req it=%0d k=%0d t=%0d got %b exp %b", it, kind, t, ram_req_o, e_req); end
                if (e_req) begin
                    n_tests++;
                    if (ram_addr_o !== aaddr[cur] || ram_we_o !== awe[cur] || ram_sel_o !== asel[cur]) begin
                        n_fail++; $display("FAIL rnd_cmd it=%0d t=%0d got %h/%b/%h exp %h/%b/%h", it, t,
                                           ram_addr_o, ram_we_o, ram_sel_o, aaddr[cur], awe[cur], asel[cur]);
                    end
                    if (awe[cur]) begin
                        n_tests++;
                        if (ram_wdata_o !== awd[cur]) begin n_fail++; $display("FAIL rnd_wdata it=%0d got %h exp %h", it, ram_wdata_o, awd[cur]); end
                    end
                end
                n_tests++;
                if (if_done_o !== e_ifd) begin n_fail++; $display("FAIL rnd_if_done it=%0d k=%0d t=%0d got %b exp %b", it, kind, t, if_done_o, e_ifd); end
                n_tests++;
                if (dm_done_o !== e_dmd) begin n_fail++; $display("FAIL rnd_dm_done it=%0d k=%0d t=%0d got %b exp %b", it, kind, t, dm_done_o, e_dmd); end
                n_tests++;
                if (if_data_o !== exp_if) begin n_fail++; $display("FAIL rnd_if_data it=%0d t=%0d got %h exp %h", it, t, if_data_o, exp_if); end
                n_tests++;
                if (dm_rdata_o !== exp_dm) begin n_fail++; $display("FAIL rnd_dm_rdata it=%0d t=%0d got %h exp %h", it, t, dm_rdata_o, exp_dm); end
                n_tests++;
                if (stallreq_from_if !== (if_req_i && !e_ifd)) begin
                    n_fail++; $display("FAIL rnd_stall_if it=%0d t=%0d got %b exp %b", it, t, stallreq_from_if, (if_req_i && !e_ifd));
                end
                n_tests++;
                if (stallreq_from_mem !== (dm_req_i && !e_dmd)) begin
                    n_fail++; $display("FAIL rnd_stall_mem it=%0d t=%0d got %b exp %b", it, t, stallreq_from_mem, (dm_req_i && !e_dmd));
                end
                for (int unsigned i = 0; i < na; i++) begin
                    if (alive[i] && t == ak[i] + lat + 2) begin
                        if (adm[i]) begin dm_req_i = 1'b0; dm_addr_i = $urandom; dm_we_i = 1'($urandom); end
                        else if_req_i = 1'b0;
                    end
                end
                if (f != 0 && t == f) begin flush_i = 1'b1; if_addr_i = aaddr[1]; end
                if (f != 0 && t == f + 1) flush_i = 1'b0;
            end
            n_tests++;
            if (err_o !== 1'b0) begin n_fail++; $display("FAIL rnd_err it=%0d got %b exp 0", it, err_o); end
            repeat ($urandom_range(0, 2)) begin
                tick();
                n_tests++;
                if (ram_req_o !== 1'b0 || if_done_o !== 1'b0 || dm_done_o !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_idle it=%0d got req=%b ifd=%b dmd=%b exp 0/0/0", it, ram_req_o, if_done_o, dm_done_o);
                end
            end
        end
        spurious_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_flush_done();
`ifdef ARB_WDOG_EN
        test_watchdog();
`endif
        test_async_reset();
        test_random_traffic(300);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported memory between the instruction-fetch stage and the data-memory (MEM) stage of the 5-stage RISC-V pipeline. It sequences each access through a req/ack handshake to the RAM and returns the read data to the requester. It raises per-requester stall requests toward ctrl so the pipeline freezes while an access is pending. Data accesses have fixed priority over fetches.

Parameters:
ADDR_W, 32, address width for both requesters and the RAM port
DATA_W, 32, data width; byte-select width is DATA_W/8
WDOG_CYCLES, 255, cycles an access may wait for ack before abort (used only with ARB_WDOG_EN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
if_req_i  in  1  fetch request, held until if_done_o
if_addr_i  in  ADDR_W  fetch address
if_data_o  out  DATA_W  fetched instruction, valid when if_done_o=1
if_done_o  out  1  one-cycle fetch-complete pulse
flush_i  in  1  branch taken: discard any pending or in-flight fetch
stallreq_from_if  out  1  if_req_i & ~if_done_o (combinational)
dm_req_i  in  1  data request, held until dm_done_o
dm_we_i  in  1  1=write, 0=read
dm_sel_i  in  DATA_W/8  byte enables
dm_addr_i  in  ADDR_W  data address
dm_wdata_i  in  DATA_W  store data
dm_rdata_o  out  DATA_W  load data, valid when dm_done_o=1
dm_done_o  out  1  one-cycle data-complete pulse
stallreq_from_mem  out  1  dm_req_i & ~dm_done_o (combinational)
ram_req_o  out  1  RAM request, held until ram_ack_i
ram_we_o, ram_sel_o, ram_addr_o, ram_wdata_o  out  1/DATA_W/8/ADDR_W/DATA_W  registered RAM command
ram_rdata_i  in  DATA_W  RAM read data, valid with ram_ack_i
ram_ack_i  in  1  RAM completion, one cycle
err_o  out  1  sticky watchdog error

Behaviour:
- Reset (async, immediate): state=IDLE; every output register is 0, including ram_req_o, the ram_* command, if_data_o, dm_rdata_o, both done pulses and err_o. Any in-flight access is abandoned.
- FSM states: IDLE, DM_BUSY, IF_BUSY.
- IDLE arbitration. A requester whose done_o is high this cycle is masked.
  - dm_req_i wins: latch the dm command into the ram_* registers, set ram_req_o, and go to DM_BUSY.
  - Otherwise, if_req_i & ~flush_i: latch if_addr_i with we=0 and sel=all ones, set ram_req_o, and go to IF_BUSY.
- BUSY: the ram_* outputs stay stable and ram_req_o stays 1 until ram_ack_i.
- On ram_ack_i:
  - Clear ram_req_o and go to IDLE.
  - Next cycle, pulse the owner's done_o. Read data is registered into if_data_o or dm_rdata_o.
  - A write leaves dm_rdata_o unchanged.
- Latency: request seen in IDLE in cycle N, ram_req_o in N+1. With ack in N+1, done_o is in N+2. Zero-wait minimum is 2 cycles per access.
- Flush:
  - flush_i in IF_BUSY sets a kill flag. The RAM access still completes, but no if_done_o is pulsed and if_data_o is not updated. The kill flag clears on ack.
  - flush_i in IDLE blocks fetch arbitration for that cycle.
  - if_done_o is forced 0 while flush_i=1.
- Simultaneous dm_req_i and if_req_i: data first; the fetch is serviced immediately after, in the IDLE cycle where dm_done_o pulses.
- ram_ack_i in IDLE is ignored.
- Data outputs hold their last value between done pulses.

Optional Feature:
Macro ARB_WDOG_EN.
- Defined: a counter clears on entry to BUSY and increments each BUSY cycle without ack. When it reaches WDOG_CYCLES:
  - drop ram_req_o and go to IDLE;
  - pulse the owner's done_o with read data 0;
  - set err_o, which stays 1 until rst.
  - A late ram_ack_i is ignored.
- Undefined: no counter; BUSY waits indefinitely; err_o tied 0.

Test Plan:
- Single fetch: if_req_i=1, addr 0x0000_0010; RAM acks 1 cycle after ram_req_o with 0x0013_0093 -> if_done_o pulses at N+2, if_data_o=0x0013_0093, stallreq_from_if high N..N+1.
- Collision: dm_req_i read 0x100 and if_req_i 0x14 in the same cycle -> ram_addr_o=0x100 first, dm_done_o pulses, then ram_addr_o=0x14, then if_done_o. No overlap on ram_req_o.
- Store: dm_we_i=1, sel=4'b0011, wdata=0xDEAD_BEEF -> ram_we_o=1, ram_sel_o=0011, wdata passes through, dm_rdata_o unchanged, dm_done_o pulses once.
- Flush in flight: fetch 0x20 in IF_BUSY, flush_i=1 one cycle, ack 3 cycles later -> no if_done_o, if_data_o keeps its old value, next fetch 0x40 serviced normally.
- Async reset mid-access: rst asserted in DM_BUSY between clock edges -> ram_req_o and all outputs 0 immediately, state IDLE after release.
- ARB_WDOG_EN, WDOG_CYCLES=4, ack never arrives -> after 4 BUSY cycles ram_req_o drops, dm_done_o pulses with dm_rdata_o=0, err_o=1 stays set.
